// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50% toggle clock or a
// one-cycle pulse train, with reconfiguration deferred to period boundaries and a global sync.
module clk_divider_multi #(
    parameter int          NCH         = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    localparam int         CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic [NCH-1:0]   cfg_pending,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] pend_div;
        logic [CNT_W-1:0] eff_div;
        logic             act_mode;
        logic             pend_mode;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             wr;
        logic             terminal;
        logic             apply;

        // A zero divisor behaves as one; pending config only lands on a period boundary.
        always_comb begin
            eff_div  = (act_div == '0) ? CNT_W'(1) : act_div;
            wr       = cfg_we && (int'(cfg_ch) == i);
            terminal = en[i] && (cnt == eff_div - CNT_W'(1));
            apply    = pend && (terminal || !en[i] || sync);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt       <= '0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
                pend      <= 1'b0;
                act_div   <= CNT_W'(DEFAULT_DIV);
                act_mode  <= 1'b0;
                pend_div  <= '0;
                pend_mode <= 1'b0;
            end else begin
                if (sync || !en[i]) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (terminal) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    clk_q  <= act_mode ? 1'b1 : ~clk_q;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                    if (act_mode) clk_q <= 1'b0;
                end

                // Apply uses the old pending value; a same-cycle write re-arms pending.
                if (apply) begin
                    act_div  <= pend_div;
                    act_mode <= pend_mode;
                    if (pend_mode != act_mode) begin
                        clk_q <= 1'b0;
                        cnt   <= '0;
                    end
                end

                if (wr) begin
                    pend_div  <= cfg_div;
                    pend_mode <= cfg_mode;
                    pend      <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign clk_out[i]     = clk_q;
        assign tick[i]        = tick_q;
        assign cfg_pending[i] = pend;
    end

endmodule
